// File: rtl/dmux8way_arbiter.sv
// Round-robin arbiter driving the select and load routing of an 8-way demultiplexed resource.
// Define DMUX8WAY_ARB_FIXED_PRIORITY_EN to pin the search pointer at 0, so the lowest index always wins.
module dmux8way_arbiter #(
    parameter int HOLD_MAX = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] req,
    input  logic       done,
    input  logic       in,
    output logic [7:0] grant,
    output logic [2:0] sel,
    output logic       busy,
    output logic [7:0] route_out
);
    localparam int HC_W = (HOLD_MAX > 0) ? $clog2(HOLD_MAX + 1) : 1;
    localparam logic [HC_W-1:0] HOLD_LIM = HC_W'(HOLD_MAX);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t          state_reg, state_next;
    logic [2:0]      ptr_reg, ptr_next;
    logic [2:0]      sel_reg, sel_next;
    logic [HC_W-1:0] hold_cnt_reg, hold_cnt_next;

    // First requester at or after p in circular order; the result is ignored when r is all zero.
    function automatic logic [2:0] find_winner(input logic [7:0] r, input logic [2:0] p);
        logic [2:0] w;
        w = p;
        for (int k = 7; k >= 0; k--) begin
            if (r[3'(p + 3'(k))]) w = 3'(p + 3'(k));
        end
        return w;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            ptr_reg      <= 3'd0;
            sel_reg      <= 3'd0;
            hold_cnt_reg <= '0;
        end else begin
            state_reg    <= state_next;
            ptr_reg      <= ptr_next;
            sel_reg      <= sel_next;
            hold_cnt_reg <= hold_cnt_next;
        end
    end

    always_comb begin
        logic       release_now;
        logic       at_limit;
        logic [2:0] new_ptr;
        state_next    = state_reg;
        ptr_next      = ptr_reg;
        sel_next      = sel_reg;
        hold_cnt_next = hold_cnt_reg;
        release_now   = 1'b0;
        at_limit      = (HOLD_MAX != 0) && (hold_cnt_reg == HOLD_LIM);
        new_ptr       = 3'd0;
        case (state_reg)
            IDLE: begin
                if (req != 8'b0) begin
                    state_next    = GRANT;
                    sel_next      = find_winner(req, ptr_reg);
                    hold_cnt_next = HC_W'(1);
                end
            end
            GRANT: begin
                release_now = done || !req[sel_reg] || at_limit;
                if (release_now) begin
`ifdef DMUX8WAY_ARB_FIXED_PRIORITY_EN
                    new_ptr = 3'd0;
`else
                    new_ptr = sel_reg + 3'd1;
`endif
                    ptr_next = new_ptr;
                    // The outgoing holder is still eligible but ranks last from the new pointer.
                    if (req != 8'b0) begin
                        sel_next      = find_winner(req, new_ptr);
                        hold_cnt_next = HC_W'(1);
                    end else begin
                        state_next    = IDLE;
                        sel_next      = 3'd0;
                        hold_cnt_next = '0;
                    end
                end else if (HOLD_MAX != 0) begin
                    hold_cnt_next = hold_cnt_reg + HC_W'(1);
                end
            end
            default: begin
                state_next = IDLE;
                sel_next   = 3'd0;
            end
        endcase
    end

    assign busy      = (state_reg == GRANT);
    assign sel       = sel_reg;
    assign grant     = busy ? (8'b1 << sel_reg) : 8'b0;
    assign route_out = busy ? ({7'b0, in} << sel_reg) : 8'b0;
endmodule

// File: tb/tb_dmux8way_arbiter.sv
// Directed bench for dmux8way_arbiter; expected outputs are queued at drive time and checked after each edge.
module tb_dmux8way_arbiter;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] req = 8'b0;
    logic       done = 1'b0;
    logic       in = 1'b0;
    logic [7:0] grant;
    logic [2:0] sel;
    logic       busy;
    logic [7:0] route_out;

    int compared = 0;
    int mismatched = 0;

    typedef struct packed {
        logic [2:0] sel;
        logic       busy;
        logic       din;
    } exp_t;
    exp_t exp_q[$];

`ifdef DMUX8WAY_ARB_FIXED_PRIORITY_EN
    localparam bit FP = 1'b1;
`else
    localparam bit FP = 1'b0;
`endif

    dmux8way_arbiter #(.HOLD_MAX(4)) dut (
        .clk(clk), .reset(reset), .req(req), .done(done), .in(in),
        .grant(grant), .sel(sel), .busy(busy), .route_out(route_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, expv);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_grant"}, grant, 8'b0);
        chk({tag, "_sel"}, {5'b0, sel}, 8'b0);
        chk({tag, "_busy"}, {7'b0, busy}, 8'b0);
        chk({tag, "_route"}, route_out, 8'b0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; req = 8'b0; done = 1'b0; in = 1'b0;
        #1 chk_idle("reset");
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic step(input string tag, input logic [7:0] r, input logic d, input logic i,
                        input logic [2:0] es, input logic eb);
        exp_t e;
        exp_t pushed;
        @(negedge clk);
        req = r; done = d; in = i;
        pushed.sel = es; pushed.busy = eb; pushed.din = i;
        exp_q.push_back(pushed);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk({tag, "_grant"}, grant, e.busy ? (8'b1 << e.sel) : 8'b0);
        chk({tag, "_sel"}, {5'b0, sel}, {5'b0, e.busy ? e.sel : 3'd0});
        chk({tag, "_busy"}, {7'b0, busy}, {7'b0, e.busy});
        chk({tag, "_route"}, route_out, e.busy ? ({7'b0, e.din} << e.sel) : 8'b0);
        $display("step %s req=%b done=%b in=%b -> grant=%b sel=%0d busy=%b route=%b",
                 tag, r, d, i, grant, sel, busy, route_out);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        // Basic grant and routing follow in.
        do_reset();
        step("t1_grant", 8'b0000_0100, 1'b0, 1'b1, 3'd2, 1'b1);
        in = 1'b0;
        #1 chk("t1_route_in0", route_out, 8'b0);
        step("t1_release", 8'b0, 1'b0, 1'b0, 3'd0, 1'b0);

        // All requesting with done every cycle: rotation with no idle gap.
        do_reset();
        step("t2_first", 8'hFF, 1'b1, 1'b1, 3'd0, 1'b1);
        for (int k = 1; k <= 8; k++)
            step("t2_rot", 8'hFF, 1'b1, 1'b1, FP ? 3'd0 : 3'(k), 1'b1);
        // Fixed priority: lane 6 keeps winning over lane 7.
        step("t2_hi", 8'b1100_0000, 1'b1, 1'b1, 3'd6, 1'b1);
        step("t2_hi_again", 8'b1100_0000, 1'b1, 1'b0, FP ? 3'd6 : 3'd7, 1'b1);
        step("t2_idle", 8'b0, 1'b0, 1'b0, 3'd0, 1'b0);

        // Hold limit forces hand-off between two persistent requesters.
        do_reset();
        step("t3_first", 8'b0000_0011, 1'b0, 1'b1, 3'd0, 1'b1);
        for (int k = 1; k <= 8; k++)
            step("t3_hold", 8'b0000_0011, 1'b0, 1'b1,
                 (FP || k < 4 || k >= 8) ? 3'd0 : 3'd1, 1'b1);

        // Drop to idle, done ignored in idle, pointer wrap.
        do_reset();
        step("t4_lane3", 8'b0000_1000, 1'b0, 1'b1, 3'd3, 1'b1);
        step("t4_drop", 8'b0, 1'b0, 1'b1, 3'd0, 1'b0);
        step("t4_done_idle", 8'b0, 1'b1, 1'b1, 3'd0, 1'b0);
        step("t4_wrap", 8'b0000_1001, 1'b0, 1'b1, 3'd0, 1'b1);

        // Non-granted request changes ignored; asynchronous reset mid-grant.
        do_reset();
        step("t5_lane5", 8'b0010_0000, 1'b0, 1'b1, 3'd5, 1'b1);
        step("t5_others", 8'b0011_1111, 1'b0, 1'b1, 3'd5, 1'b1);
        #2 reset = 1'b1;
        #1 chk_idle("t5_async");
        @(negedge clk);
        reset = 1'b0;
        step("t5_after", 8'b1000_0001, 1'b0, 1'b1, 3'd0, 1'b1);
        step("t5_both", 8'b1000_0001, 1'b1, 1'b1, FP ? 3'd0 : 3'd7, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
